// File: rtl/sram_pkg.sv
// Shared constants, FSM state encoding and byte-lane helper for the SRAM responder.
package sram_pkg;

   localparam int unsigned MEM_DEPTH = 256;
   localparam int unsigned ROM_WORDS = 32;
   localparam int unsigned ADDR_W    = 20;
   localparam int unsigned DATA_W    = 16;
   localparam int unsigned RAM_AW    = $clog2(MEM_DEPTH);
   localparam int unsigned ROM_AW    = $clog2(ROM_WORDS);

   localparam logic [ADDR_W-1:0] IO_ADDR = 20'hFFFFF;

   typedef enum logic [2:0] {INIT, IDLE, RD1, RD2, WR1, WR2} state_t;

   typedef struct packed {
      logic hi;
      logic lo;
   } lanes_t;

   function automatic logic [DATA_W-1:0] merge_lanes(input logic [DATA_W-1:0] old_w,
                                                     input logic [DATA_W-1:0] new_w,
                                                     input lanes_t            en);
      return {en.hi ? new_w[15:8] : old_w[15:8],
              en.lo ? new_w[7:0]  : old_w[7:0]};
   endfunction

endpackage

// File: rtl/sram_responder_if.sv
// Async-SRAM style bus between the CPU-side initiator and the responder.
interface sram_responder_if;
   import sram_pkg::*;

   logic              Mem_CE;
   logic              Mem_UB;
   logic              Mem_LB;
   logic              Mem_OE;
   logic              Mem_WE;
   logic [ADDR_W-1:0] ADDR;
   logic [DATA_W-1:0] Data_to_SRAM;
   logic [DATA_W-1:0] Switches;
   logic [DATA_W-1:0] Data_from_SRAM;
   logic [DATA_W-1:0] HEX_Data;
   logic              Init_Done;
   logic              Proto_Err;

   modport master (
      output Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE, ADDR, Data_to_SRAM, Switches,
      input  Data_from_SRAM, HEX_Data, Init_Done, Proto_Err
   );

   modport slave (
      input  Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE, ADDR, Data_to_SRAM, Switches,
      output Data_from_SRAM, HEX_Data, Init_Done, Proto_Err
   );

endinterface

// File: rtl/program_rom.sv
// Program image copied into RAM during INIT; combinational lookup.
module program_rom
   import sram_pkg::*;
(
   input  logic [ROM_AW-1:0] addr,
   output logic [DATA_W-1:0] word_c
);

   assign word_c = {3'b101, addr, 3'b000, addr};

endmodule

// File: rtl/sram_responder.sv
// Cycle-accurate SRAM responder: loads a program image, then serves two-cycle
// reads and byte-lane writes, with one memory-mapped I/O word.
module sram_responder
   import sram_pkg::*;
(
   input  logic               Clk,
   input  logic               Reset,
   sram_responder_if.slave    sram
);

   logic [DATA_W-1:0] mem [MEM_DEPTH];

   state_t            state;
   logic [RAM_AW-1:0] init_cnt;
   logic [DATA_W-1:0] rd_data;
   logic [DATA_W-1:0] hex_data;
   logic              init_done;
   logic              proto_err;
   logic              wr_block;

   logic              ce_c, oe_c, we_c, io_hit_c, rd_go_c;
   logic [RAM_AW-1:0] ram_idx_c;
   logic [DATA_W-1:0] rom_word_c, rd_word_c;
   lanes_t            wr_lanes_c;

   assign ce_c       = !sram.Mem_CE;
   assign oe_c       = !sram.Mem_OE;
   assign we_c       = !sram.Mem_WE;
   assign ram_idx_c  = sram.ADDR[RAM_AW-1:0];
   assign io_hit_c   = (sram.ADDR == IO_ADDR);
   assign rd_go_c    = ce_c && oe_c && !we_c;
   assign rd_word_c  = io_hit_c ? sram.Switches : mem[ram_idx_c];
   assign wr_lanes_c = '{hi: !sram.Mem_UB, lo: !sram.Mem_LB};

   program_rom u_rom (
      .addr   (init_cnt[ROM_AW-1:0]),
      .word_c (rom_word_c)
   );

   // RAM write port: INIT sweep or WR2 commit, never in a reset cycle.
   lanes_t            ram_we_c;
   logic [RAM_AW-1:0] ram_waddr_c;
   logic [DATA_W-1:0] ram_wdata_c;

   always_comb begin
      ram_we_c    = '{hi: 1'b0, lo: 1'b0};
      ram_waddr_c = ram_idx_c;
      ram_wdata_c = sram.Data_to_SRAM;
      if (!Reset) begin
         if (state == INIT) begin
            ram_we_c    = '{hi: 1'b1, lo: 1'b1};
            ram_waddr_c = init_cnt;
            ram_wdata_c = (32'(init_cnt) < ROM_WORDS) ? rom_word_c : '0;
         end else if (state == WR2 && ce_c && !io_hit_c) begin
            ram_we_c = wr_lanes_c;
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (ram_we_c.hi) mem[ram_waddr_c][15:8] <= ram_wdata_c[15:8];
      if (ram_we_c.lo) mem[ram_waddr_c][7:0]  <= ram_wdata_c[7:0];
   end

   // Bus FSM; wr_block keeps a held-low WE from re-triggering a commit.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state     <= INIT;
         init_cnt  <= '0;
         rd_data   <= '0;
         hex_data  <= '0;
         init_done <= 1'b0;
         proto_err <= 1'b0;
         wr_block  <= 1'b0;
      end else begin
         if (state != INIT && ce_c && oe_c && we_c) proto_err <= 1'b1;
         case (state)
            INIT: begin
               init_cnt <= init_cnt + RAM_AW'(1);
               if (init_cnt == RAM_AW'(MEM_DEPTH - 1)) begin
                  state     <= IDLE;
                  init_done <= 1'b1;
               end
            end
            IDLE: begin
               wr_block <= wr_block && ce_c && we_c;
               if (!ce_c) begin
                  state <= IDLE;
               end else if (we_c) begin
                  state <= wr_block ? IDLE : WR1;
               end else if (oe_c) begin
                  state   <= RD1;
                  rd_data <= rd_word_c;
               end
            end
            RD1: begin
               if (rd_go_c) begin
                  state   <= RD2;
                  rd_data <= rd_word_c;
               end else begin
                  state <= IDLE;
               end
            end
            RD2:     state <= rd_go_c ? RD2 : IDLE;
            WR1:     state <= (ce_c && we_c) ? WR2 : IDLE;
            WR2: begin
               state    <= IDLE;
               wr_block <= ce_c && we_c;
               if (ce_c && io_hit_c) hex_data <= merge_lanes(hex_data, sram.Data_to_SRAM, wr_lanes_c);
            end
            default: state <= INIT;
         endcase
      end
   end

   assign sram.Data_from_SRAM = rd_data;
   assign sram.HEX_Data       = hex_data;
   assign sram.Init_Done      = init_done;
   assign sram.Proto_Err      = proto_err;

endmodule
